// File: rtl/piso_serialiser_pkg.sv
// Shared definitions for the parallel-in/serial-out serialiser: FSM state
// encoding and the level driven on the serial line when no data bit is shown.
package piso_serialiser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } piso_state_t;

   // Serial line level whenever SER_VALID is low (idle and inter-word gap).
   localparam logic IDLE_SER_LEVEL = 1'b0;

endpackage : piso_serialiser_pkg

// File: rtl/piso_serialiser_if.sv
// Word-in / bit-out bundle between a word source and the serialiser.
// The master side supplies words and the bit-rate strobe; the slave side
// (the serialiser) returns the handshake, the serial stream and status.
interface piso_serialiser_if #(
   parameter int REG_WIDTH = 8
);
   logic                 BIT_TICK;
   logic [REG_WIDTH-1:0] IN_DATA;
   logic                 IN_VALID;
   logic                 IN_READY;
   logic                 SER_OUT;
   logic                 SER_VALID;
   logic                 FRAME_START;
   logic                 BUSY;

   modport master (
      output BIT_TICK,
      output IN_DATA,
      output IN_VALID,
      input  IN_READY,
      input  SER_OUT,
      input  SER_VALID,
      input  FRAME_START,
      input  BUSY
   );

   modport slave (
      input  BIT_TICK,
      input  IN_DATA,
      input  IN_VALID,
      output IN_READY,
      output SER_OUT,
      output SER_VALID,
      output FRAME_START,
      output BUSY
   );
endinterface : piso_serialiser_if

// File: rtl/piso_hold_reg.sv
// One-entry holding register in front of the shifter. A word is taken when
// in_valid is high while the entry is empty; the shifter frees the entry by
// pulsing consume when it copies the word into its shift register.
// in_ready comes straight from the full flag so the source sees no
// combinational path from its own in_valid.
module piso_hold_reg #(
   parameter int REG_WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 RESETN,
   input  logic [REG_WIDTH-1:0] in_data,
   input  logic                 in_valid,
   input  logic                 consume,
   output logic [REG_WIDTH-1:0] hold_data,
   output logic                 hold_full,
   output logic                 in_ready
);

   logic                 full_reg;
   logic                 full_next;
   logic [REG_WIDTH-1:0] data_reg;
   logic [REG_WIDTH-1:0] data_next;
   logic                 accept;

   assign in_ready  = !full_reg;
   assign accept    = in_valid && !full_reg;
   assign hold_data = data_reg;
   assign hold_full = full_reg;

   // Entry occupancy and contents: a new accept refills, a consume empties.
   always_comb begin
      full_next = accept || (full_reg && !consume);
      data_next = accept ? in_data : data_reg;
   end

   // Occupancy and data registers; reset discards any held word.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         full_reg <= 1'b0;
         data_reg <= '0;
      end else begin
         full_reg <= full_next;
         data_reg <= data_next;
      end
   end

endmodule : piso_hold_reg

// File: rtl/piso_serialiser.sv
// Parallel-in/serial-out serialiser. Words arrive through a one-entry holding
// register and are shifted out one bit per BIT_TICK, optionally followed by
// GAP_BITS idle bit periods. A word waiting in the holding register starts
// straight after the previous word's gap without passing through IDLE.
module piso_serialiser #(
   parameter int REG_WIDTH = 8,
   parameter int MSB_FIRST = 1,
   parameter int GAP_BITS  = 1
) (
   input  logic             CLK,
   input  logic             RESETN,
   piso_serialiser_if.slave bus
);
   import piso_serialiser_pkg::*;

   localparam int BW = $clog2(REG_WIDTH);
   // A zero-length gap never enters GAP, but the counter still needs a width.
   localparam int GW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(REG_WIDTH - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
   localparam logic          HAS_GAP  = (GAP_BITS > 0);

   piso_state_t          state_reg;
   piso_state_t          state_next;
   logic [REG_WIDTH-1:0] shift_reg;
   logic [REG_WIDTH-1:0] shift_next;
   logic [REG_WIDTH-1:0] shift_adv;
   logic [BW-1:0]        bit_cnt_reg;
   logic [BW-1:0]        bit_cnt_next;
   logic [GW-1:0]        gap_cnt_reg;
   logic [GW-1:0]        gap_cnt_next;

   logic [REG_WIDTH-1:0] hold_data;
   logic                 hold_full;
   logic                 hold_ready;
   logic                 consume;
   logic                 start_word;
   logic                 gap_over;

   logic                 shift_out_bit;
   logic                 ser_out;
   logic                 ser_valid;
   logic                 frame_start;

   piso_hold_reg #(
      .REG_WIDTH (REG_WIDTH)
   ) u_hold (
      .CLK       (CLK),
      .RESETN    (RESETN),
      .in_data   (bus.IN_DATA),
      .in_valid  (bus.IN_VALID),
      .consume   (consume),
      .hold_data (hold_data),
      .hold_full (hold_full),
      .in_ready  (hold_ready)
   );

   // Shift-by-one toward the output end; the vacated end fills with zero.
   genvar gi;
   generate
      for (gi = 0; gi < REG_WIDTH; gi++) begin : g_shift
         if (MSB_FIRST != 0) begin : g_up
            if (gi == 0) begin : g_fill
               assign shift_adv[gi] = 1'b0;
            end else begin : g_move
               assign shift_adv[gi] = shift_reg[gi-1];
            end
         end else begin : g_down
            if (gi == REG_WIDTH - 1) begin : g_fill
               assign shift_adv[gi] = 1'b0;
            end else begin : g_move
               assign shift_adv[gi] = shift_reg[gi+1];
            end
         end
      end

      if (MSB_FIRST != 0) begin : g_tap_msb
         assign shift_out_bit = shift_reg[REG_WIDTH-1];
      end else begin : g_tap_lsb
         assign shift_out_bit = shift_reg[0];
      end
   endgenerate

   // Next-state logic: word/gap sequencing, counters, and reload from hold.
   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt_reg;
      gap_cnt_next = gap_cnt_reg;
      start_word   = 1'b0;
      gap_over     = 1'b0;
      consume      = 1'b0;

      unique case (state_reg)
         ST_IDLE: begin
            // Loading is not tick-gated; a coincident tick is simply ignored.
            if (hold_full) begin
               start_word = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (bus.BIT_TICK) begin
               if (bit_cnt_reg == BIT_LAST) begin
                  if (HAS_GAP) begin
                     state_next   = ST_GAP;
                     gap_cnt_next = '0;
                  end else begin
                     gap_over = 1'b1;
                  end
               end else begin
                  shift_next   = shift_adv;
                  bit_cnt_next = bit_cnt_reg + 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (bus.BIT_TICK) begin
               if (gap_cnt_reg == GAP_LAST) begin
                  gap_over = 1'b1;
               end else begin
                  gap_cnt_next = gap_cnt_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // End of gap: chain straight into the held word if there is one.
      if (gap_over) begin
         if (hold_full) begin
            start_word = 1'b1;
         end else begin
            state_next = ST_IDLE;
         end
      end

      if (start_word) begin
         state_next   = ST_SHIFT;
         shift_next   = hold_data;
         bit_cnt_next = '0;
         consume      = 1'b1;
      end
   end

   // State, shift register and counters; reset abandons any word in flight.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_reg   <= ST_IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         gap_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         bit_cnt_reg <= bit_cnt_next;
         gap_cnt_reg <= gap_cnt_next;
      end
   end

   // Serial outputs decoded from state so they go idle as soon as reset asserts.
   always_comb begin
      ser_out     = IDLE_SER_LEVEL;
      ser_valid   = 1'b0;
      frame_start = 1'b0;
      if (state_reg == ST_SHIFT) begin
         ser_out     = shift_out_bit;
         ser_valid   = 1'b1;
         frame_start = (bit_cnt_reg == '0);
      end
   end

   assign bus.SER_OUT     = ser_out;
   assign bus.SER_VALID   = ser_valid;
   assign bus.FRAME_START = frame_start;
   assign bus.IN_READY    = hold_ready;
   assign bus.BUSY        = (state_reg != ST_IDLE) || hold_full;

endmodule : piso_serialiser

// File: tb/tb_piso_serialiser.sv
// Directed bench for piso_serialiser: an MSB-first one-gap instance (A) and an
// LSB-first gapless instance (B) share clock and reset. BIT_TICK pulses once
// every four cycles while enabled. Outputs are sampled 1 time unit after posedge.
module tb_piso_serialiser;

   logic CLK;
   logic RESETN;

   int tests_run;
   int tests_failed;
   int cyc;
   int phase;
   bit tick_en;

   piso_serialiser_if #(.REG_WIDTH(8)) bus_a ();
   piso_serialiser_if #(.REG_WIDTH(8)) bus_b ();

   piso_serialiser #(
      .REG_WIDTH (8),
      .MSB_FIRST (1),
      .GAP_BITS  (1)
   ) dut_a (
      .CLK    (CLK),
      .RESETN (RESETN),
      .bus    (bus_a)
   );

   piso_serialiser #(
      .REG_WIDTH (8),
      .MSB_FIRST (0),
      .GAP_BITS  (0)
   ) dut_b (
      .CLK    (CLK),
      .RESETN (RESETN),
      .bus    (bus_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance one clock and update the tick strobe for the following cycle.
   task automatic cycle();
      @(posedge CLK);
      #1;
      cyc++;
      phase = (phase + 1) % 4;
      bus_a.BIT_TICK = tick_en && (phase == 0);
      bus_b.BIT_TICK = tick_en && (phase == 0);
   endtask

   task automatic ticks_on();
      tick_en = 1'b1;
      phase   = 0;
   endtask

   task automatic ticks_off();
      tick_en        = 1'b0;
      bus_a.BIT_TICK = 1'b0;
      bus_b.BIT_TICK = 1'b0;
   endtask

   // Advance until the strobe is high for the current cycle (bounded).
   task automatic wait_tick(input string tag);
      int n;
      n = 0;
      while (!bus_a.BIT_TICK && n < 40) begin
         cycle();
         n++;
      end
      if (!bus_a.BIT_TICK) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s tick_timeout: no BIT_TICK after %0d cycles, required within 40", tag, n);
      end
   endtask

   // Check each bit of a word on instance A at the cycle its tick is consumed.
   task automatic stream_word_a(input logic [7:0] w, input logic exp_ready, input string tag);
      logic exp_bit;
      logic exp_fs;
      for (int i = 0; i < 8; i++) begin
         wait_tick(tag);
         exp_bit = w[7-i];
         exp_fs  = (i == 0);
         tests_run++;
         if (bus_a.SER_OUT !== exp_bit || bus_a.SER_VALID !== 1'b1 ||
             bus_a.FRAME_START !== exp_fs || bus_a.IN_READY !== exp_ready) begin
            tests_failed++;
            $display("FAIL %s bit%0d: got out=%b valid=%b frame=%b ready=%b, required out=%b valid=1 frame=%b ready=%b",
                     tag, i, bus_a.SER_OUT, bus_a.SER_VALID, bus_a.FRAME_START, bus_a.IN_READY,
                     exp_bit, exp_fs, exp_ready);
         end else begin
            $display("[TB] %s bit%0d out=%b frame=%b ok", tag, i, bus_a.SER_OUT, bus_a.FRAME_START);
         end
         cycle();
      end
   endtask

   // Check the single idle gap period on instance A, then consume its tick.
   task automatic gap_a(input logic exp_ready, input string tag);
      wait_tick(tag);
      tests_run++;
      if (bus_a.SER_VALID !== 1'b0 || bus_a.SER_OUT !== 1'b0 || bus_a.FRAME_START !== 1'b0 ||
          bus_a.BUSY !== 1'b1 || bus_a.IN_READY !== exp_ready) begin
         tests_failed++;
         $display("FAIL %s gap: got valid=%b out=%b frame=%b busy=%b ready=%b, required 0 0 0 1 %b",
                  tag, bus_a.SER_VALID, bus_a.SER_OUT, bus_a.FRAME_START, bus_a.BUSY, bus_a.IN_READY, exp_ready);
      end else begin
         $display("[TB] %s gap ok", tag);
      end
      cycle();
   endtask

   task automatic test_reset();
      RESETN = 1'b1;
      #1;
      RESETN = 1'b0;
      #1;
      tests_run++;
      if (bus_a.SER_OUT !== 1'b0 || bus_a.SER_VALID !== 1'b0 || bus_a.FRAME_START !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_serial: got out=%b valid=%b frame=%b, required 0 0 0",
                  bus_a.SER_OUT, bus_a.SER_VALID, bus_a.FRAME_START);
      end else $display("[TB] reset serial outputs idle");
      tests_run++;
      if (bus_a.IN_READY !== 1'b1 || bus_a.BUSY !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_status: got ready=%b busy=%b, required 1 0", bus_a.IN_READY, bus_a.BUSY);
      end else $display("[TB] reset ready=1 busy=0");
      cycle();
      cycle();
      tests_run++;
      if (bus_b.SER_VALID !== 1'b0 || bus_b.IN_READY !== 1'b1 || bus_b.BUSY !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_b: got valid=%b ready=%b busy=%b, required 0 1 0",
                  bus_b.SER_VALID, bus_b.IN_READY, bus_b.BUSY);
      end else $display("[TB] reset instance B idle");
      RESETN = 1'b1;
      cycle();
   endtask

   task automatic test_single_word();
      ticks_off();
      bus_a.IN_DATA  = 8'hA5;
      bus_a.IN_VALID = 1'b1;
      cycle();
      bus_a.IN_VALID = 1'b0;
      tests_run++;
      if (bus_a.IN_READY !== 1'b0 || bus_a.BUSY !== 1'b1 || bus_a.SER_VALID !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_accept: got ready=%b busy=%b valid=%b, required 0 1 0",
                  bus_a.IN_READY, bus_a.BUSY, bus_a.SER_VALID);
      end else $display("[TB] single accept held");
      cycle();
      tests_run++;
      if (bus_a.SER_VALID !== 1'b1 || bus_a.FRAME_START !== 1'b1 || bus_a.SER_OUT !== 1'b1 ||
          bus_a.IN_READY !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_latency: got valid=%b frame=%b out=%b ready=%b, required 1 1 1 1",
                  bus_a.SER_VALID, bus_a.FRAME_START, bus_a.SER_OUT, bus_a.IN_READY);
      end else $display("[TB] single first bit two cycles after accept");
      ticks_on();
      stream_word_a(8'hA5, 1'b1, "single");
      gap_a(1'b1, "single");
      tests_run++;
      if (bus_a.BUSY !== 1'b0 || bus_a.SER_VALID !== 1'b0 || bus_a.IN_READY !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_idle: got busy=%b valid=%b ready=%b, required 0 0 1",
                  bus_a.BUSY, bus_a.SER_VALID, bus_a.IN_READY);
      end else $display("[TB] single back to idle");
   endtask

   task automatic test_back_to_back();
      int t0;
      ticks_off();
      bus_a.IN_DATA  = 8'hA5;
      bus_a.IN_VALID = 1'b1;
      cycle();
      bus_a.IN_DATA = 8'h3C;
      cycle();
      tests_run++;
      if (bus_a.IN_READY !== 1'b1 || bus_a.SER_VALID !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_free: got ready=%b valid=%b, required 1 1", bus_a.IN_READY, bus_a.SER_VALID);
      end else $display("[TB] b2b hold freed by A5 load");
      cycle();
      bus_a.IN_DATA = 8'hFF;
      tests_run++;
      if (bus_a.IN_READY !== 1'b0 || bus_a.SER_VALID !== 1'b1 || bus_a.SER_OUT !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_3c_held: got ready=%b valid=%b out=%b, required 0 1 1",
                  bus_a.IN_READY, bus_a.SER_VALID, bus_a.SER_OUT);
      end else $display("[TB] b2b 3C accepted during A5");
      ticks_on();
      stream_word_a(8'hA5, 1'b0, "b2b_A5");
      t0 = cyc;
      gap_a(1'b0, "b2b_A5");
      tests_run++;
      if (bus_a.FRAME_START !== 1'b1 || bus_a.SER_VALID !== 1'b1 || bus_a.SER_OUT !== 1'b0 ||
          bus_a.IN_READY !== 1'b1 || (cyc - t0) != 4) begin
         tests_failed++;
         $display("FAIL b2b_3c_start: got frame=%b valid=%b out=%b ready=%b delay=%0d, required 1 1 0 1 delay=4",
                  bus_a.FRAME_START, bus_a.SER_VALID, bus_a.SER_OUT, bus_a.IN_READY, cyc - t0);
      end else $display("[TB] b2b 3C starts one gap period after A5");
      cycle();
      bus_a.IN_VALID = 1'b0;
      tests_run++;
      if (bus_a.IN_READY !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_ff_held: got ready=%b, required 0", bus_a.IN_READY);
      end else $display("[TB] b2b FF accepted into hold");
      stream_word_a(8'h3C, 1'b0, "b2b_3C");
      gap_a(1'b0, "b2b_3C");
      stream_word_a(8'hFF, 1'b1, "b2b_FF");
      gap_a(1'b1, "b2b_FF");
      tests_run++;
      if (bus_a.BUSY !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_idle: got busy=%b, required 0", bus_a.BUSY);
      end else $display("[TB] b2b idle after FF");
   endtask

   task automatic test_lsb_nogap();
      logic [7:0] w;
      logic       exp_bit;
      logic       exp_fs;
      ticks_off();
      bus_b.IN_DATA  = 8'h01;
      bus_b.IN_VALID = 1'b1;
      cycle();
      bus_b.IN_DATA = 8'h80;
      cycle();
      cycle();
      bus_b.IN_VALID = 1'b0;
      tests_run++;
      if (bus_b.IN_READY !== 1'b0 || bus_b.SER_VALID !== 1'b1) begin
         tests_failed++;
         $display("FAIL lsb_setup: got ready=%b valid=%b, required 0 1", bus_b.IN_READY, bus_b.SER_VALID);
      end else $display("[TB] lsb 80 held behind 01");
      ticks_on();
      for (int k = 0; k < 2; k++) begin
         w = (k == 0) ? 8'h01 : 8'h80;
         for (int i = 0; i < 8; i++) begin
            wait_tick("lsb");
            exp_bit = w[i];
            exp_fs  = (i == 0);
            tests_run++;
            if (bus_b.SER_OUT !== exp_bit || bus_b.SER_VALID !== 1'b1 || bus_b.FRAME_START !== exp_fs) begin
               tests_failed++;
               $display("FAIL lsb word%0d bit%0d: got out=%b valid=%b frame=%b, required out=%b valid=1 frame=%b",
                        k, i, bus_b.SER_OUT, bus_b.SER_VALID, bus_b.FRAME_START, exp_bit, exp_fs);
            end else begin
               $display("[TB] lsb word%0d bit%0d out=%b ok", k, i, bus_b.SER_OUT);
            end
            cycle();
         end
         if (k == 0) begin
            tests_run++;
            if (bus_b.FRAME_START !== 1'b1 || bus_b.SER_VALID !== 1'b1) begin
               tests_failed++;
               $display("FAIL lsb_nogap: got frame=%b valid=%b right after word0, required 1 1",
                        bus_b.FRAME_START, bus_b.SER_VALID);
            end else $display("[TB] lsb second word follows with no gap");
         end
      end
      tests_run++;
      if (bus_b.BUSY !== 1'b0 || bus_b.SER_VALID !== 1'b0) begin
         tests_failed++;
         $display("FAIL lsb_idle: got busy=%b valid=%b, required 0 0", bus_b.BUSY, bus_b.SER_VALID);
      end else $display("[TB] lsb idle after 80");
   endtask

   task automatic test_reset_midword();
      logic [7:0] w;
      logic       exp_bit;
      w = 8'hA5;
      ticks_off();
      bus_a.IN_DATA  = 8'hA5;
      bus_a.IN_VALID = 1'b1;
      cycle();
      bus_a.IN_DATA = 8'h3C;
      cycle();
      cycle();
      bus_a.IN_VALID = 1'b0;
      ticks_on();
      for (int i = 0; i < 3; i++) begin
         wait_tick("rst_mid");
         exp_bit = w[7-i];
         tests_run++;
         if (bus_a.SER_OUT !== exp_bit || bus_a.SER_VALID !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid bit%0d: got out=%b valid=%b, required %b 1", i, bus_a.SER_OUT, bus_a.SER_VALID, exp_bit);
         end else $display("[TB] rst_mid bit%0d ok", i);
         cycle();
      end
      tests_run++;
      if (bus_a.SER_VALID !== 1'b1 || bus_a.BUSY !== 1'b1 || bus_a.IN_READY !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_mid_bit3: got valid=%b busy=%b ready=%b, required 1 1 0",
                  bus_a.SER_VALID, bus_a.BUSY, bus_a.IN_READY);
      end else $display("[TB] rst_mid on bit3 with 3C held");
      #3;
      RESETN = 1'b0;
      #1;
      tests_run++;
      if (bus_a.SER_OUT !== 1'b0 || bus_a.SER_VALID !== 1'b0 || bus_a.FRAME_START !== 1'b0 ||
          bus_a.IN_READY !== 1'b1 || bus_a.BUSY !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_async: got out=%b valid=%b frame=%b ready=%b busy=%b, required 0 0 0 1 0",
                  bus_a.SER_OUT, bus_a.SER_VALID, bus_a.FRAME_START, bus_a.IN_READY, bus_a.BUSY);
      end else $display("[TB] rst_async outputs idle before any clock edge");
      cycle();
      cycle();
      RESETN = 1'b1;
      ticks_off();
      cycle();
      bus_a.IN_DATA  = 8'hFF;
      bus_a.IN_VALID = 1'b1;
      cycle();
      bus_a.IN_VALID = 1'b0;
      cycle();
      ticks_on();
      stream_word_a(8'hFF, 1'b1, "post_rst");
      gap_a(1'b1, "post_rst");
      tests_run++;
      if (bus_a.BUSY !== 1'b0 || bus_a.SER_VALID !== 1'b0 || bus_a.IN_READY !== 1'b1) begin
         tests_failed++;
         $display("FAIL post_rst_idle: got busy=%b valid=%b ready=%b, required 0 0 1 (3C must be gone)",
                  bus_a.BUSY, bus_a.SER_VALID, bus_a.IN_READY);
      end else $display("[TB] post_rst idle, discarded word never sent");
   endtask

   task automatic test_tick_stall();
      int moved;
      ticks_off();
      bus_a.IN_DATA  = 8'h80;
      bus_a.IN_VALID = 1'b1;
      cycle();
      bus_a.IN_VALID = 1'b0;
      cycle();
      bus_a.IN_DATA  = 8'h55;
      bus_a.IN_VALID = 1'b1;
      cycle();
      bus_a.IN_VALID = 1'b0;
      moved = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus_a.SER_OUT !== 1'b1 || bus_a.SER_VALID !== 1'b1 || bus_a.FRAME_START !== 1'b1) moved++;
         cycle();
      end
      tests_run++;
      if (moved != 0) begin
         tests_failed++;
         $display("FAIL stall_frozen: got %0d cycles off first bit, required 0", moved);
      end else $display("[TB] stall first bit frozen for 30 cycles");
      tests_run++;
      if (bus_a.SER_OUT !== 1'b1 || bus_a.SER_VALID !== 1'b1 || bus_a.FRAME_START !== 1'b1 ||
          bus_a.IN_READY !== 1'b0 || bus_a.BUSY !== 1'b1) begin
         tests_failed++;
         $display("FAIL stall_state: got out=%b valid=%b frame=%b ready=%b busy=%b, required 1 1 1 0 1",
                  bus_a.SER_OUT, bus_a.SER_VALID, bus_a.FRAME_START, bus_a.IN_READY, bus_a.BUSY);
      end else $display("[TB] stall second word held, ready low");
   endtask

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      cyc            = 0;
      phase          = 0;
      tick_en        = 1'b0;
      bus_a.BIT_TICK = 1'b0;
      bus_a.IN_DATA  = '0;
      bus_a.IN_VALID = 1'b0;
      bus_b.BIT_TICK = 1'b0;
      bus_b.IN_DATA  = '0;
      bus_b.IN_VALID = 1'b0;

      test_reset();
      test_single_word();
      test_back_to_back();
      test_lsb_nogap();
      test_reset_midword();
      test_tick_stall();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_piso_serialiser
